// File: rtl/music_player_ctrl.sv
// Beat sequencer for the tone table: walks beat_num at a selectable tempo under
// play/pause/stop control and registers the looked-up tone toward the note generator.
module music_player_ctrl #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BEAT_FREQ = 8,
    parameter int unsigned LAST_BEAT = 224,
    parameter logic [31:0] SILENCE   = 32'd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop_en,
    input  logic        mute,
    input  logic [1:0]  tempo_sel,
    input  logic [31:0] tone_in,
    output logic [7:0]  beat_num,
    output logic [31:0] tone_out,
    output logic        playing,
    output logic        paused,
    output logic        beat_tick,
    output logic        done
);

    localparam int unsigned DIV = CLK_FREQ / BEAT_FREQ;
    localparam int unsigned TW  = $clog2(DIV * 2 + 1);
    localparam int unsigned BW  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt, tick_nxt;
    logic [TW-1:0]   cur_div_c;
    logic [BW-1:0]   beat_nxt;
    logic            tick_hit_c;
    logic            done_c;
    logic            boundary_c;

    // Beat length in clocks for the currently selected tempo
    always_comb begin
        cur_div_c = TW'(DIV);
        case (tempo_sel)
            2'd1:    cur_div_c = TW'(DIV / 2);
            2'd2:    cur_div_c = TW'(DIV * 2);
            default: cur_div_c = TW'(DIV);
        endcase
    end

    // Compared as tick_cnt+1 >= CUR_DIV so a shrinking tempo still advances next cycle
    assign boundary_c = ((TW+1)'(tick_cnt) + (TW+1)'(1)) >= (TW+1)'(cur_div_c);

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat_num;
        tick_nxt   = tick_cnt;
        tick_hit_c = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                beat_nxt = '0;
                tick_nxt = '0;
                if (play && !pause && !stop) begin
                    state_nxt = PLAY;
                    beat_nxt  = BW'(1);
                end
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                    tick_nxt  = '0;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end else if (boundary_c) begin
                    tick_nxt   = '0;
                    tick_hit_c = 1'b1;
                    if (beat_num < BW'(LAST_BEAT)) begin
                        beat_nxt = beat_num + BW'(1);
                    end else if (loop_en) begin
                        beat_nxt = BW'(1);
                    end else begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                        done_c    = 1'b1;
                    end
                end else begin
                    tick_nxt = tick_cnt + TW'(1);
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                    tick_nxt  = '0;
                end else if (!pause && play) begin
                    state_nxt = PLAY;
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
                tick_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_num  <= '0;
            tick_cnt  <= '0;
            tone_out  <= SILENCE;
            playing   <= 1'b0;
            paused    <= 1'b0;
            beat_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_num  <= beat_nxt;
            tick_cnt  <= tick_nxt;
            tone_out  <= (state == PLAY && !mute) ? tone_in : SILENCE;
            playing   <= (state_nxt == PLAY);
            paused    <= (state_nxt == PAUSE);
            beat_tick <= tick_hit_c;
            done      <= done_c;
        end
    end

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed bench for music_player_ctrl at DIV=10: a vector table for the main
// play/tempo/pause/mute flow, plus hand sequences for reset and end-of-song.
module tb_music_player_ctrl;

    localparam logic [31:0] S = 32'd20000;

    logic        clk = 1'b0;
    logic        rst, play, pause, stop, loop_en, mute;
    logic [1:0]  tempo_sel;
    logic [31:0] tone_in, tone_in_s;
    logic [7:0]  beat_num, beat_num_s;
    logic [31:0] tone_out, tone_out_s;
    logic        playing, paused, beat_tick, done;
    logic        playing_s, paused_s, beat_tick_s, done_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign tone_in   = 32'd300 + 32'(beat_num);
    assign tone_in_s = 32'd300 + 32'(beat_num_s);

    music_player_ctrl #(.CLK_FREQ(80), .BEAT_FREQ(8), .LAST_BEAT(224), .SILENCE(S)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .loop_en(loop_en), .mute(mute), .tempo_sel(tempo_sel), .tone_in(tone_in),
        .beat_num(beat_num), .tone_out(tone_out), .playing(playing), .paused(paused),
        .beat_tick(beat_tick), .done(done)
    );

    music_player_ctrl #(.CLK_FREQ(80), .BEAT_FREQ(8), .LAST_BEAT(3), .SILENCE(S)) dut_s (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .loop_en(loop_en), .mute(mute), .tempo_sel(tempo_sel), .tone_in(tone_in_s),
        .beat_num(beat_num_s), .tone_out(tone_out_s), .playing(playing_s), .paused(paused_s),
        .beat_tick(beat_tick_s), .done(done_s)
    );

    typedef struct {
        logic        play, pause, stop, mute;
        logic [1:0]  tempo;
        int          n;
        logic [7:0]  beat;
        logic [31:0] tone;
        logic        playing, paused, tick, done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic pl, logic pa, logic st, logic mu, logic [1:0] tp, int n,
                                logic [7:0] b, logic [31:0] t, logic ep, logic eu,
                                logic et, logic ed);
        vec_t v;
        v.play = pl; v.pause = pa; v.stop = st; v.mute = mu; v.tempo = tp; v.n = n;
        v.beat = b; v.tone = t; v.playing = ep; v.paused = eu; v.tick = et; v.done = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic pl, input logic pa, input logic st);
        play = pl; pause = pa; stop = st;
        step();
        play = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".beat"},    32'(beat_num),  32'd0);
        chk({tag, ".tone"},    tone_out,       S);
        chk({tag, ".playing"}, 32'(playing),   32'd0);
        chk({tag, ".paused"},  32'(paused),    32'd0);
        chk({tag, ".tick"},    32'(beat_tick), 32'd0);
        chk({tag, ".done"},    32'(done),      32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0;
        loop_en = 1'b0; mute = 1'b0; tempo_sel = 2'd0;

        //        pl pa st mu tp  n   beat tone  ply pau tick done
        tbl.push_back(mk(1, 0, 0, 0, 0,  1,  1, S,   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,  1, 301, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  9,  2, 301, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,  2, 302, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  9,  3, 302, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1,  3, S,   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  9,  4, S,   1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,  4, 304, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  4,  5, 304, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  5,  6, 305, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  4,  6, 306, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 15,  6, 306, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2,  1,  7, 306, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10,  8, 307, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 10,  9, 308, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  6,  9, 309, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1,  9, 309, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,  9, S,   0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 48,  9, S,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1,  9, S,   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  3,  9, 309, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 10, 309, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  9, 10, 310, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 10, 310, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 10, S,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 10, S,   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 11, 310, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 11, 311, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  1,  0, 311, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,  0, S,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1,  0, S,   0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  1,  0, S,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1,  1, S,   1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1,  1, 301, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,  1,  0, S,   0, 0, 0, 0));

        do_reset();
        chk_reset_vals("reset");

        // Main table: levels held for the whole row, command pulses on its first cycle only
        foreach (tbl[i]) begin
            mute = tbl[i].mute;
            tempo_sel = tbl[i].tempo;
            pulse(tbl[i].play, tbl[i].pause, tbl[i].stop);
            steps(tbl[i].n - 1);
            chk($sformatf("v%0d.beat", i),    32'(beat_num),  32'(tbl[i].beat));
            chk($sformatf("v%0d.tone", i),    tone_out,       tbl[i].tone);
            chk($sformatf("v%0d.playing", i), 32'(playing),   32'(tbl[i].playing));
            chk($sformatf("v%0d.paused", i),  32'(paused),    32'(tbl[i].paused));
            chk($sformatf("v%0d.tick", i),    32'(beat_tick), 32'(tbl[i].tick));
            chk($sformatf("v%0d.done", i),    32'(done),      32'(tbl[i].done));
        end
        mute = 1'b0; tempo_sel = 2'd0;

        // Reset mid-song at beat 2
        pulse(1'b1, 1'b0, 1'b0);
        steps(10);
        chk("mid.beat", 32'(beat_num), 32'd2);
        chk("mid.tone", tone_out, 32'd301);
        do_reset();
        chk_reset_vals("midrst");

        // End of song without loop (LAST_BEAT=3 instance)
        loop_en = 1'b0;
        dones = 0;
        pulse(1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 30; c++) begin
            step();
            dones += int'(done_s);
        end
        chk("end.beat_pre", 32'(beat_num_s), 32'd3);
        chk("end.done_pre", 32'(dones), 32'd0);
        step();
        chk("end.beat", 32'(beat_num_s), 32'd0);
        chk("end.done", 32'(done_s), 32'd1);
        chk("end.playing", 32'(playing_s), 32'd0);
        chk("end.paused", 32'(paused_s), 32'd0);
        chk("end.tick", 32'(beat_tick_s), 32'd1);
        chk("end.tone", tone_out_s, 32'd303);
        step();
        chk("end.done_gone", 32'(done_s), 32'd0);
        chk("end.tone_sil", tone_out_s, S);
        chk("end.beat_idle", 32'(beat_num_s), 32'd0);

        // Same song with loop: wraps 3 -> 1, no done
        do_reset();
        loop_en = 1'b1;
        dones = 0;
        pulse(1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 31; c++) begin
            step();
            dones += int'(done_s);
        end
        chk("loop.beat", 32'(beat_num_s), 32'd1);
        chk("loop.tick", 32'(beat_tick_s), 32'd1);
        chk("loop.playing", 32'(playing_s), 32'd1);
        steps(10);
        dones += int'(done_s);
        chk("loop.beat2", 32'(beat_num_s), 32'd2);
        chk("loop.no_done", 32'(dones), 32'd0);
        loop_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
